// File: rtl/gpx_pkg.sv
// Shared constants and FSM state encoding for the GPX result-frame packer.
package gpx_pkg;

  localparam int          DATA_W   = 16;
  localparam int          N_WORDS  = 300;
  localparam logic [15:0] HDR_WORD = 16'hA55A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CNT  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } state_t;

endpackage

// File: rtl/gpx_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a synchronous flush.
// A word written in cycle T is presented on rd_data in cycle T+1.
module gpx_sync_fifo #(
  parameter int W  = 17,
  parameter int AW = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_fire, rd_fire;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign wr_fire = wr_en && !full && !flush;
  assign rd_fire = rd_en && !empty && !flush;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/gpx_frame_pack.sv
// Captures result-RAM words behind the read sequencer and emits them as
// framed words (header, frame count, data, checksum) on a valid/ready stream.
module gpx_frame_pack #(
  parameter int                 DATA_W   = gpx_pkg::DATA_W,
  parameter int                 N_WORDS  = gpx_pkg::N_WORDS,
  parameter int                 RAM_LAT  = 1,
  parameter int                 FIFO_AW  = 9,
  parameter logic [DATA_W-1:0]  HDR_WORD = gpx_pkg::HDR_WORD
) (
  input  logic              clk_fpga,
  input  logic              rst,
  input  logic              in_re_start,
  input  logic              in_rd_e,
  input  logic [8:0]        in_rd_addr,
  input  logic              in_rd_sof,
  input  logic [DATA_W-1:0] in_ram_dout,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_last,
  input  logic              in_ready,
  output logic [15:0]       out_frame_cnt,
  output logic              out_ovf,
  output logic              out_trunc,
  output logic [1:0]        dbg_state,
  output logic              dbg_addr_err
);

  import gpx_pkg::*;

  localparam int TW = DATA_W + 1;
  localparam int CW = $clog2(N_WORDS + 1);

  // Alignment pipe: rd_e/sof delayed to line up with returning RAM data.
  logic [RAM_LAT-1:0] rde_pipe_q, rde_pipe_d;
  logic [RAM_LAT-1:0] sof_pipe_q, sof_pipe_d;
  logic               ovf_q, ovf_d;
  logic [8:0]         addr_nxt_q, addr_nxt_d;
  logic               addr_arm_q, addr_arm_d;
  logic               addr_err_q, addr_err_d;

  logic               wr_en;
  logic [TW-1:0]      wr_data;
  logic [TW-1:0]      head;
  logic               head_tag;
  logic [DATA_W-1:0]  head_data;
  logic               fifo_full, fifo_empty;
  logic               pop;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_sof_q, out_sof_d;
  logic               out_last_q, out_last_d;
  logic [DATA_W-1:0]  csum_q, csum_d;
  logic [CW-1:0]      word_cnt_q, word_cnt_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               trunc_q, trunc_d;
  logic               adv;

  assign wr_en     = rde_pipe_q[RAM_LAT-1];
  assign wr_data   = {sof_pipe_q[RAM_LAT-1], in_ram_dout};
  assign head_tag  = head[TW-1];
  assign head_data = head[DATA_W-1:0];

  gpx_sync_fifo #(
    .W  (TW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk_fpga),
    .rst     (rst),
    .flush   (in_re_start),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Capture side: alignment, overflow status and sequencer address sanity.
  always_comb begin
    rde_pipe_d = RAM_LAT'({rde_pipe_q, in_rd_e});
    sof_pipe_d = RAM_LAT'({sof_pipe_q, in_rd_sof});
    ovf_d      = ovf_q | (wr_en & fifo_full);
    addr_nxt_d = addr_nxt_q;
    addr_arm_d = addr_arm_q;
    addr_err_d = addr_err_q;
    if (in_rd_e) begin
      if (in_rd_sof && in_rd_addr != 9'd0) addr_err_d = 1'b1;
      if (addr_arm_q && !in_rd_sof && in_rd_addr != addr_nxt_q) addr_err_d = 1'b1;
      addr_nxt_d = in_rd_addr + 9'd1;
      addr_arm_d = addr_arm_q | in_rd_sof;
    end
    if (in_re_start) begin
      rde_pipe_d = '0;
      sof_pipe_d = '0;
      ovf_d      = 1'b0;
      addr_nxt_d = '0;
      addr_arm_d = 1'b0;
      addr_err_d = 1'b0;
    end
  end

  // Stream handshake: a word transfers on a clock edge where out_valid and
  // in_ready are both high; while out_valid=1 and in_ready=0 every stream
  // output holds, and out_valid never drops without a transfer except on
  // restart/reset. The FSM only advances when the output register is free.
  assign adv = !out_valid_q || in_ready;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sof_d   = out_sof_q;
    out_last_d  = out_last_q;
    csum_d      = csum_q;
    word_cnt_d  = word_cnt_q;
    frame_cnt_d = frame_cnt_q;
    trunc_d     = trunc_q;
    pop         = 1'b0;

    if (out_valid_q && out_last_q && in_ready) frame_cnt_d = frame_cnt_q + 16'd1;

    if (adv) begin
      out_valid_d = 1'b0;
      out_sof_d   = 1'b0;
      out_last_d  = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            if (head_tag) begin
              out_data_d  = HDR_WORD;
              out_valid_d = 1'b1;
              out_sof_d   = 1'b1;
              state_d     = CNT;
            end else begin
              pop = 1'b1;  // orphan word outside any frame
            end
          end
        end
        CNT: begin
          out_data_d  = DATA_W'(frame_cnt_q);
          out_valid_d = 1'b1;
          csum_d      = '0;
          word_cnt_d  = '0;
          state_d     = DATA;
        end
        DATA: begin
          if (!fifo_empty) begin
            // The frame's own first word carries the tag; later tags start a new frame.
            if (head_tag && word_cnt_q != '0) begin
              trunc_d = 1'b1;
              state_d = CSUM;
            end else begin
              pop         = 1'b1;
              out_data_d  = head_data;
              out_valid_d = 1'b1;
              csum_d      = csum_q + head_data;
              word_cnt_d  = word_cnt_q + CW'(1);
              if (word_cnt_q == CW'(N_WORDS - 1)) state_d = CSUM;
            end
          end
        end
        CSUM: begin
          out_data_d  = csum_q;
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          state_d     = IDLE;
        end
      endcase
    end

    if (in_re_start) begin
      state_d     = IDLE;
      out_data_d  = '0;
      out_valid_d = 1'b0;
      out_sof_d   = 1'b0;
      out_last_d  = 1'b0;
      csum_d      = '0;
      word_cnt_d  = '0;
      frame_cnt_d = '0;
      trunc_d     = 1'b0;
      pop         = 1'b0;
    end
  end

  always_ff @(posedge clk_fpga or posedge rst) begin
    if (rst) begin
      rde_pipe_q  <= '0;
      sof_pipe_q  <= '0;
      ovf_q       <= 1'b0;
      addr_nxt_q  <= '0;
      addr_arm_q  <= 1'b0;
      addr_err_q  <= 1'b0;
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_last_q  <= 1'b0;
      csum_q      <= '0;
      word_cnt_q  <= '0;
      frame_cnt_q <= '0;
      trunc_q     <= 1'b0;
    end else begin
      rde_pipe_q  <= rde_pipe_d;
      sof_pipe_q  <= sof_pipe_d;
      ovf_q       <= ovf_d;
      addr_nxt_q  <= addr_nxt_d;
      addr_arm_q  <= addr_arm_d;
      addr_err_q  <= addr_err_d;
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_last_q  <= out_last_d;
      csum_q      <= csum_d;
      word_cnt_q  <= word_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      trunc_q     <= trunc_d;
    end
  end

  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_sof       = out_sof_q;
  assign out_last      = out_last_q;
  assign out_frame_cnt = frame_cnt_q;
  assign out_ovf       = ovf_q;
  assign out_trunc     = trunc_q;
  assign dbg_state     = state_q;
  assign dbg_addr_err  = addr_err_q;

endmodule

// File: tb/tb_gpx_frame_pack.sv
// Directed bench for gpx_frame_pack: sequencer/RAM model driving bursts and a
// stream scoreboard comparing every accepted word against hand-built frames.
module tb_gpx_frame_pack;

  import gpx_pkg::*;

  logic        clk_fpga = 1'b0;
  logic        rst;
  logic        in_re_start;
  logic        in_rd_e;
  logic [8:0]  in_rd_addr;
  logic        in_rd_sof;
  logic [15:0] in_ram_dout = 16'h0;
  logic [15:0] out_data;
  logic        out_valid, out_sof, out_last;
  logic        in_ready;
  logic [15:0] out_frame_cnt;
  logic        out_ovf, out_trunc;
  logic [1:0]  dbg_state;
  logic        dbg_addr_err;

  int          checks   = 0;
  int          failures = 0;
  logic [17:0] exp_q[$];
  logic [15:0] exp_frame_cnt;
  logic        rand_ready   = 1'b0;
  logic        hold_pending = 1'b0;
  logic [17:0] held;

  gpx_frame_pack dut (
    .clk_fpga      (clk_fpga),
    .rst           (rst),
    .in_re_start   (in_re_start),
    .in_rd_e       (in_rd_e),
    .in_rd_addr    (in_rd_addr),
    .in_rd_sof     (in_rd_sof),
    .in_ram_dout   (in_ram_dout),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_sof       (out_sof),
    .out_last      (out_last),
    .in_ready      (in_ready),
    .out_frame_cnt (out_frame_cnt),
    .out_ovf       (out_ovf),
    .out_trunc     (out_trunc),
    .dbg_state     (dbg_state),
    .dbg_addr_err  (dbg_addr_err)
  );

  // ---------------- clock ----------------
  always #5 clk_fpga = ~clk_fpga;

  // Result RAM model: dout = addr, one cycle latency.
  always @(posedge clk_fpga) if (in_rd_e) in_ram_dout <= 16'(in_rd_addr);

  // 50% random backpressure when enabled.
  always @(posedge clk_fpga) if (rand_ready) #1 in_ready = 1'($urandom_range(0, 1));

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Stream scoreboard; entries are {sof, last, data}.
  always @(negedge clk_fpga) begin
    logic [17:0] got;
    got = {out_sof, out_last, out_data};
    if (hold_pending) check_eq("hold_stable", 64'({out_valid, got}), 64'({1'b1, held}));
    hold_pending = !rst && out_valid && !in_ready;
    held         = got;
    if (!rst && out_valid && in_ready) begin
      if (exp_q.size() == 0) check_eq("stream_extra_word", 64'(exp_q.size()), 64'd1);
      else                   check_eq("stream_word", 64'(got), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame(input int n, input logic [15:0] csum);
    exp_q.push_back({2'b10, HDR_WORD});
    exp_q.push_back({2'b00, exp_frame_cnt});
    for (int i = 0; i < n; i++) exp_q.push_back({2'b00, 16'(i)});
    exp_q.push_back({2'b01, csum});
    exp_frame_cnt++;
  endtask

  task automatic burst(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_fpga); #1;
      in_rd_e    = 1'b1;
      in_rd_addr = 9'(i);
      in_rd_sof  = (i == 0);
    end
    @(posedge clk_fpga); #1;
    in_rd_e   = 1'b0;
    in_rd_sof = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < budget) begin
      @(negedge clk_fpga);
      k++;
    end
    check_eq(tag, 64'(k < budget), 64'd1);
  endtask

  task automatic wait_data(input string tag, input logic [15:0] val);
    int k = 0;
    do begin
      @(negedge clk_fpga);
      k++;
    end while (!(out_valid && !out_sof && !out_last && out_data == val) && k < 2000);
    check_eq(tag, 64'(k < 2000), 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; in_re_start = 1'b0; in_rd_e = 1'b0; in_rd_addr = '0;
    in_rd_sof = 1'b0; in_ready = 1'b1; exp_frame_cnt = 16'd0;
    repeat (3) @(posedge clk_fpga);
    @(negedge clk_fpga);
    check_eq("reset_state", 64'({out_valid, out_sof, out_last, out_ovf, out_trunc,
                                 dbg_addr_err, dbg_state, out_frame_cnt, out_data}), 64'd0);
    @(posedge clk_fpga); #1 rst = 1'b0;

    // Nominal frame
    push_frame(300, 16'hAF32);
    burst(300);
    drain("nominal_drain", 2000);
    check_eq("nominal_frame_cnt", 64'(out_frame_cnt), 64'd1);
    check_eq("nominal_flags", 64'({out_ovf, out_trunc}), 64'd0);

    // Random backpressure
    push_frame(300, 16'hAF32);
    rand_ready = 1'b1;
    burst(300);
    drain("bp_drain", 3000);
    rand_ready = 1'b0;
    in_ready   = 1'b1;
    check_eq("bp_frame_cnt", 64'(out_frame_cnt), 64'd2);
    check_eq("bp_ovf", 64'(out_ovf), 64'd0);

    // Truncation: new sof after 100 reads
    push_frame(100, 16'h1356);
    push_frame(300, 16'hAF32);
    burst(100);
    burst(300);
    drain("trunc_drain", 2000);
    check_eq("trunc_flag", 64'(out_trunc), 64'd1);
    check_eq("trunc_frame_cnt", 64'(out_frame_cnt), 64'd4);

    // Restart at data word 150
    push_frame(300, 16'hAF32);
    fork
      burst(300);
      begin
        wait_data("restart_reach", 16'd150);
        @(posedge clk_fpga); #1 in_re_start = 1'b1;
        @(posedge clk_fpga); #1 in_re_start = 1'b0;
        exp_q.delete();
        @(negedge clk_fpga);
        check_eq("restart_clear", 64'({out_valid, out_last, out_ovf, out_trunc, out_frame_cnt}), 64'd0);
      end
    join
    exp_frame_cnt = 16'd0;
    push_frame(300, 16'hAF32);
    burst(300);
    drain("restart_drain", 2000);
    check_eq("restart_frame_cnt", 64'(out_frame_cnt), 64'd1);

    // Overflow: two bursts with the host stalled
    @(posedge clk_fpga); #1 in_ready = 1'b0;
    burst(300);
    burst(300);
    repeat (4) @(negedge clk_fpga);
    check_eq("ovf_set", 64'(out_ovf), 64'd1);
    check_eq("ovf_header_held", 64'({out_valid, out_sof, out_data}), 64'({2'b11, HDR_WORD}));
    push_frame(300, 16'hAF32);
    push_frame(212, 16'h575E);
    push_frame(300, 16'hAF32);
    @(posedge clk_fpga); #1 in_ready = 1'b1;
    repeat (700) @(posedge clk_fpga);
    check_eq("ovf_partial_pending", 64'(exp_q.size()), 64'd304);
    burst(300);
    drain("ovf_drain", 2000);
    check_eq("ovf_trunc", 64'(out_trunc), 64'd1);
    check_eq("ovf_sticky", 64'(out_ovf), 64'd1);
    check_eq("ovf_frame_cnt", 64'(out_frame_cnt), 64'd4);

    // Asynchronous reset mid-frame
    push_frame(300, 16'hAF32);
    fork
      burst(300);
      begin
        wait_data("areset_reach", 16'd100);
        #2 rst = 1'b1;
        #1;
        check_eq("areset_outputs", 64'({out_valid, out_sof, out_last, out_ovf, out_trunc,
                                        dbg_state, out_frame_cnt, out_data}), 64'd0);
        exp_q.delete();
        repeat (3) @(posedge clk_fpga);
        #1 rst = 1'b0;
      end
    join
    exp_frame_cnt = 16'd0;
    push_frame(300, 16'hAF32);
    burst(300);
    drain("areset_drain", 2000);
    check_eq("areset_frame_cnt", 64'(out_frame_cnt), 64'd1);
    check_eq("areset_flags", 64'({out_ovf, out_trunc, dbg_addr_err}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpx_frame_pack.md
Name: gpx_frame_pack

Overview:
- Downstream stage of the GPX result-read sequencer. It consumes the read-enable, address and start-of-frame strobes the sequencer drives into the result RAM, and captures the returned RAM words.
- Captured words are buffered in a tagged FIFO and emitted as framed 16-bit words on a valid/ready stream toward the host link.
- Frame format: header word, frame count, N_WORDS data words, checksum.
- The block absorbs host backpressure, because the read sequencer never stalls.

Parameters:
- DATA_W, 16: RAM data / stream word width.
- N_WORDS, 300: data words per complete frame. Equals the sequencer's read count.
- RAM_LAT, 1: cycles from in_rd_e/in_rd_addr to valid in_ram_dout.
- FIFO_AW, 9: FIFO address width; depth is 2^FIFO_AW = 512 entries.
- HDR_WORD, 16'hA55A: frame header value.

Ports:
- clk_fpga  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_re_start  in  1  synchronous restart: flush and clear status.
- in_rd_e  in  1  sequencer read enable; one RAM word returns per asserted cycle.
- in_rd_addr  in  9  sequencer read address; used only for debug compare.
- in_rd_sof  in  1  first read of a burst (address 0).
- in_ram_dout  in  DATA_W  result RAM read data; valid RAM_LAT cycles after in_rd_e.
- out_data  out  DATA_W  stream word.
- out_valid  out  1  stream word valid.
- out_sof  out  1  marks the header word.
- out_last  out  1  marks the checksum word.
- in_ready  in  1  downstream accept.
- out_frame_cnt  out  16  completed frames since reset or restart.
- out_ovf  out  1  sticky: a RAM word was dropped because the FIFO was full.
- out_trunc  out  1  sticky: a frame was closed before N_WORDS data words.

Behaviour:
- Reset: all outputs and the FIFO return to 0/empty; the FSM goes to IDLE. in_re_start has the same effect synchronously, and wins over every same-cycle event.
- Alignment: in_rd_e and in_rd_sof pass through a RAM_LAT-deep shift register. When the delayed rd_e is high, {delayed_sof, in_ram_dout} is written into the FIFO (DATA_W+1 bits wide).
- FIFO full on write: the word is dropped and out_ovf is set. It stays set until rst or in_re_start.
- FIFO is first-word-fall-through: a word written in cycle T is visible at the head in cycle T+1.
- Output register: out_data, out_valid, out_sof and out_last are all registered. The FSM advances only when (!out_valid || in_ready). While out_valid=1 and in_ready=0, all stream outputs hold stable.
- FSM states:
  - IDLE: if the head is tagged, load HDR_WORD with out_sof=1 and go to CNT. If the head is untagged (orphan), pop and discard it and stay in IDLE.
  - CNT: load out_frame_cnt and go to DATA. Clear the 16-bit checksum accumulator and the word counter.
  - DATA: when the head is present and untagged, pop it, load it, add it to the checksum (mod 2^16) and increment the counter. When the counter reaches N_WORDS, go to CSUM. If the head is tagged before N_WORDS words, set out_trunc and go to CSUM without popping. An empty FIFO stalls (out_valid=0).
  - CSUM: load the checksum with out_last=1. Increment out_frame_cnt (wraps 0xFFFF->0) when the word is accepted, then go to IDLE.
- Latency: with in_ready=1, the header is valid in cycle T+2, where T is the write cycle of the tagged word. A full frame is N_WORDS+3 contiguous words.
- Throughput: one word per cycle. With in_ready held high, FIFO occupancy stays ≤4.
- Restart mid-frame: out_valid drops the next cycle with no out_last; the partial frame is abandoned and out_frame_cnt is not incremented.

Decomposition:
- gpx_pkg holds: HDR_WORD, N_WORDS, DATA_W, and the FSM state enum (IDLE, CNT, DATA, CSUM).
- Sub-module gpx_sync_fifo: FWFT, parameterised width/depth, synchronous flush input, full/empty flags.
- The framing FSM, alignment pipe and checksum stay in gpx_frame_pack.

Test Plan:
- Nominal frame: RAM model dout=addr, RAM_LAT=1, one 300-read burst, in_ready=1 -> 303 words: A55A, 0000, 0..299, checksum 0xAF32; out_sof on word 1, out_last on word 303; out_frame_cnt=1.
- Backpressure: in_ready toggled at 50% random during the frame -> identical word sequence, no drop, out_ovf=0, each word held stable while stalled.
- Overflow: in_ready=0 for 2 bursts (600 words > 512) -> out_ovf=1; with in_ready=1 afterwards, no hang, and frames stay delimited by out_sof/out_last.
- Truncation: second sof injected after 100 reads -> first frame has 100 data words, checksum 0x1356, out_trunc=1; second frame follows complete.
- Restart: in_re_start at data word 150 -> out_valid=0 next cycle, out_frame_cnt=0, flags cleared; the next burst produces a clean frame with count 0000.
- Async reset asserted mid-frame -> all outputs 0 immediately; after release, a burst produces a correct frame.
